shield_loader: RTL and testbench

Write-side controller for the 2048x1 shield (blanking) map, organised as 32 bearings x 64 range cells. It takes host byte traffic and clear commands, then sequences one-bit writes onto the shield block's write port (wraddr/wrdata/wren). The shield block edge-detects wren, so every bit write needs its own separate low-high-low strobe with address and data held stable. The block sits between the host/config register interface and the shield block, on the shield write clock.

---
 rtl/shield_pkg.sv | 20 ++
 rtl/shield_strobe_gen.sv | 33 +++
 rtl/shield_loader.sv | 157 +++++++++++++++
 tb/tb_shield_loader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shield_pkg.sv
// Shared geometry and FSM state constants for the shield map write path.
// The map is 32 bearings x 64 range cells, addressed as {bearing, range}.
package shield_pkg;

  localparam int unsigned BEAR_W         = 5;
  localparam int unsigned RANGE_W        = 6;
  localparam int unsigned ADDR_W         = 11;
  localparam int unsigned CELLS          = 2048;
  localparam int unsigned BYTES_PER_BEAR = 8;

  localparam int unsigned STATE_W = 6;

  localparam logic [STATE_W-1:0] ST_IDLE      = 6'b000001;
  localparam logic [STATE_W-1:0] ST_WAIT_BYTE = 6'b000010;
  localparam logic [STATE_W-1:0] ST_SETUP     = 6'b000100;
  localparam logic [STATE_W-1:0] ST_STROBE    = 6'b001000;
  localparam logic [STATE_W-1:0] ST_HOLD      = 6'b010000;
  localparam logic [STATE_W-1:0] ST_DONE      = 6'b100000;

endpackage

// File: rtl/shield_strobe_gen.sv
// Per-bit slot timer: counts STROBE (PULSE_W) and HOLD (GAP_W) cycles and
// flags the last cycle of each phase.
module shield_strobe_gen #(
  parameter int unsigned PULSE_W = 1,
  parameter int unsigned GAP_W   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_strobe,
  input  logic i_hold,
  output logic o_pulse_last,
  output logic o_slot_done
);

  localparam logic [2:0] PULSE_LAST = 3'(PULSE_W - 1);
  localparam logic [2:0] GAP_LAST   = 3'(GAP_W - 1);

  logic [2:0] r_cnt;

  assign o_pulse_last = i_strobe && (r_cnt == PULSE_LAST);
  assign o_slot_done  = i_hold && (r_cnt == GAP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (o_pulse_last || o_slot_done || !(i_strobe || i_hold)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shield_loader.sv
// Write-side sequencer for the shield map: turns host bytes and clear commands
// into isolated single-bit write strobes with address/data held around each.
import shield_pkg::*;

module shield_loader #(
  parameter int unsigned PULSE_W = 1,
  parameter int unsigned GAP_W   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_clr,
  input  logic              load_start,
  input  logic [BEAR_W-1:0] load_bear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddr,
  output logic              wrdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_nxt;
  logic               r_clr_mode;
  logic [ADDR_W-1:0]  r_addr;
  logic [7:0]         r_shift;
  logic [2:0]         r_bit_idx;
  logic [3:0]         r_byte_cnt;
  logic               r_wren, r_wrdata, r_byte_ready, r_busy, r_done, r_err;

  logic w_in_strobe, w_in_hold, w_pulse_last, w_slot_done;
  logic w_idle, w_last_cell, w_last_bit, w_last_byte, w_err;

  assign w_in_strobe = (r_state == ST_STROBE);
  assign w_in_hold   = (r_state == ST_HOLD);
  assign w_idle      = (r_state == ST_IDLE);
  assign w_last_cell = (r_addr == ADDR_W'(CELLS - 1));
  assign w_last_bit  = (r_bit_idx == 3'd7);
  assign w_last_byte = (r_byte_cnt == 4'(BYTES_PER_BEAR));
  assign w_err       = (!w_idle && (cmd_clr || load_start)) ||
                       (w_idle && (byte_valid || (cmd_clr && load_start)));

  shield_strobe_gen #(
    .PULSE_W (PULSE_W),
    .GAP_W   (GAP_W)
  ) u_strobe (
    .clk          (clk),
    .rst_n        (reset),
    .i_strobe     (w_in_strobe),
    .i_hold       (w_in_hold),
    .o_pulse_last (w_pulse_last),
    .o_slot_done  (w_slot_done)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_clr)         w_nxt = ST_SETUP;
        else if (load_start) w_nxt = ST_WAIT_BYTE;
      end
      ST_WAIT_BYTE: if (byte_valid) w_nxt = ST_SETUP;
      ST_SETUP:     w_nxt = ST_STROBE;
      ST_STROBE:    if (w_pulse_last) w_nxt = ST_HOLD;
      ST_HOLD: begin
        if (w_slot_done) begin
          if (r_clr_mode)       w_nxt = w_last_cell ? ST_DONE : ST_SETUP;
          else if (!w_last_bit) w_nxt = ST_SETUP;
          else if (!w_last_byte) w_nxt = ST_WAIT_BYTE;
          else                  w_nxt = ST_DONE;
        end
      end
      ST_DONE: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_clr_mode <= 1'b0;
      r_addr     <= '0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_byte_cnt <= '0;
      r_wrdata   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        ST_IDLE: begin
          if (cmd_clr) begin
            r_clr_mode <= 1'b1;
            r_addr     <= '0;
            r_wrdata   <= 1'b0;
          end else if (load_start) begin
            r_addr     <= {load_bear, {RANGE_W{1'b0}}};
            r_byte_cnt <= '0;
          end
        end
        ST_WAIT_BYTE: begin
          if (byte_valid) begin
            r_shift    <= byte_data;
            r_bit_idx  <= '0;
            r_byte_cnt <= r_byte_cnt + 1'b1;
            r_wrdata   <= byte_data[0];
          end
        end
        ST_HOLD: begin
          // Address/data only move once the gap has elapsed, so they stay
          // stable across the whole SETUP..HOLD slot.
          if (w_slot_done) begin
            if (r_clr_mode) begin
              r_addr <= r_addr + 1'b1;
            end else if (!w_last_bit) begin
              r_shift                <= r_shift >> 1;
              r_wrdata               <= r_shift[1];
              r_bit_idx              <= r_bit_idx + 1'b1;
              r_addr[RANGE_W-1:0]    <= r_addr[RANGE_W-1:0] + 1'b1;
            end else if (!w_last_byte) begin
              r_addr[RANGE_W-1:0]    <= r_addr[RANGE_W-1:0] + 1'b1;
            end
          end
        end
        ST_DONE: r_clr_mode <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wren       <= 1'b0;
      r_byte_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_wren       <= (w_nxt == ST_STROBE);
      r_byte_ready <= (w_nxt == ST_WAIT_BYTE);
      r_busy       <= (w_nxt != ST_IDLE);
      r_done       <= (w_nxt == ST_DONE);
      r_err        <= w_err;
    end
  end

  assign wren       = r_wren;
  assign wraddr     = r_addr;
  assign wrdata     = r_wrdata;
  assign byte_ready = r_byte_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_shield_loader.sv
// Scoreboard bench for shield_loader: stimulus pushes expected writes, done and
// err cycles; negedge monitors pop and compare as the DUTs present them.
module tb_shield_loader;
  import shield_pkg::*;

  localparam int unsigned P1 = 1, G1 = 1, S1 = 1 + P1 + G1;
  localparam int unsigned P2 = 2, G2 = 3, S2 = 1 + P2 + G2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              cmd_clr, load_start, byte_valid;
  logic [BEAR_W-1:0] load_bear;
  logic [7:0]        byte_data;
  logic              byte_ready, wren, wrdata, busy, done, err;
  logic [ADDR_W-1:0] wraddr;

  logic              cmd_clr2, load_start2, byte_valid2;
  logic [BEAR_W-1:0] load_bear2;
  logic [7:0]        byte_data2;
  logic              byte_ready2, wren2, wrdata2, busy2, done2, err2;
  logic [ADDR_W-1:0] wraddr2;

  shield_loader u_dut (
    .clk(clk), .reset(rst_n), .cmd_clr(cmd_clr), .load_start(load_start),
    .load_bear(load_bear), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
    .busy(busy), .done(done), .err(err)
  );

  shield_loader #(.PULSE_W(P2), .GAP_W(G2)) u_dut2 (
    .clk(clk), .reset(rst_n), .cmd_clr(cmd_clr2), .load_start(load_start2),
    .load_bear(load_bear2), .byte_valid(byte_valid2), .byte_data(byte_data2),
    .byte_ready(byte_ready2), .wren(wren2), .wraddr(wraddr2), .wrdata(wrdata2),
    .busy(busy2), .done(done2), .err(err2)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  wr_t         q_wr[$], q_wr2[$];
  int unsigned q_done[$], q_err[$], q_done2[$], q_err2[$];

  logic [7:0]  ld_bytes [8];
  int unsigned ld_gaps  [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event not expected or bound expired (cycle %0d)", name, cyc);
  endtask

  // Monitor for the default-timing DUT
  logic        prev_wren = 1'b0;
  int unsigned rise_cyc = 0;
  wr_t         cur_wr;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wren <= 1'b0;
    end else begin
      if (wren && !prev_wren) begin
        if (q_wr.size() == 0) flag("unexpected_write");
        else begin
          check("wr_addr", wraddr, q_wr[0].addr);
          check("wr_data", wrdata, q_wr[0].data);
          void'(q_wr.pop_front());
        end
        cur_wr   <= '{addr: wraddr, data: wrdata};
        rise_cyc <= cyc;
      end
      if (!wren && prev_wren) begin
        check("pulse_width", cyc - rise_cyc, P1);
        check("hold_stable", {wraddr, wrdata}, cur_wr);
      end
      if (done) begin
        if (q_done.size() == 0) flag("unexpected_done");
        else check("done_cycle", cyc, q_done.pop_front());
      end
      if (err) begin
        if (q_err.size() == 0) flag("unexpected_err");
        else check("err_cycle", cyc, q_err.pop_front());
      end
      prev_wren <= wren;
    end
  end

  // Monitor for the PULSE_W=2 / GAP_W=3 DUT, including slot period
  logic        prev_wren2 = 1'b0;
  logic        have_rise2 = 1'b0;
  int unsigned rise2 = 0;
  wr_t         cur_wr2;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wren2 <= 1'b0;
      have_rise2 <= 1'b0;
    end else begin
      if (wren2 && !prev_wren2) begin
        if (q_wr2.size() == 0) flag("unexpected_write2");
        else begin
          check("wr_addr2", wraddr2, q_wr2[0].addr);
          check("wr_data2", wrdata2, q_wr2[0].data);
          void'(q_wr2.pop_front());
        end
        if (have_rise2) check("bit_period2", cyc - rise2, S2);
        cur_wr2    <= '{addr: wraddr2, data: wrdata2};
        rise2      <= cyc;
        have_rise2 <= 1'b1;
      end
      if (!wren2 && prev_wren2) begin
        check("pulse_width2", cyc - rise2, P2);
        check("hold_stable2", {wraddr2, wrdata2}, cur_wr2);
      end
      if (done2) begin
        have_rise2 <= 1'b0;
        if (q_done2.size() == 0) flag("unexpected_done2");
        else check("done_cycle2", cyc, q_done2.pop_front());
      end
      if (err2) begin
        if (q_err2.size() == 0) flag("unexpected_err2");
        else check("err_cycle2", cyc, q_err2.pop_front());
      end
      prev_wren2 <= wren2;
    end
  end

  task automatic wait_ready(input string name);
    int unsigned guard = 0;
    while (!byte_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) flag(name);
  endtask

  // Expected writes come straight from the bit-to-cell mapping; done time from
  // the per-byte schedule: first byte one cycle after load_start, each byte
  // then occupies 8 slots plus one WAIT_BYTE cycle, plus any host stall.
  task automatic do_load(input logic [BEAR_W-1:0] bear);
    int unsigned start_cyc = cyc;
    int unsigned tot_gap = 0;
    for (int k = 0; k < 8; k++) begin
      tot_gap += ld_gaps[k];
      for (int j = 0; j < 8; j++)
        q_wr.push_back('{addr: {bear, 6'(8 * k + j)}, data: ld_bytes[k][j]});
    end
    q_done.push_back(start_cyc + 8 * (8 * S1 + 1) + 1 + tot_gap);
    load_bear  = bear;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (ld_gaps[k] != 0) begin
        byte_valid = 1'b0;
        wait_ready("stall_ready_timeout");
        for (int g = 0; g < int'(ld_gaps[k]); g++) begin
          check("stall_ready", byte_ready, 1);
          check("stall_wren", wren, 0);
          @(negedge clk);
        end
      end
      byte_valid = 1'b1;
      byte_data  = ld_bytes[k];
      wait_ready("byte_ready_timeout");
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic issue_clear();
    for (int i = 0; i < int'(CELLS); i++) q_wr.push_back('{addr: ADDR_W'(i), data: 1'b0});
    q_done.push_back(cyc + CELLS * S1 + 1);
    cmd_clr = 1'b1;
    @(negedge clk);
    cmd_clr = 1'b0;
  endtask

  task automatic drain();
    int unsigned guard = 0;
    while ((q_wr.size() != 0 || q_done.size() != 0 || q_err.size() != 0 ||
            q_wr2.size() != 0 || q_done2.size() != 0 || q_err2.size() != 0) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) flag("drain_timeout");
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_ready", byte_ready, 0);
    check("idle_busy2", busy2, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned guard;
    logic [BEAR_W-1:0] b;
    rst_n = 1'b0;
    cmd_clr = 1'b0; load_start = 1'b0; load_bear = '0; byte_valid = 1'b0; byte_data = '0;
    cmd_clr2 = 1'b0; load_start2 = 1'b0; load_bear2 = '0; byte_valid2 = 1'b0; byte_data2 = '0;
    repeat (3) @(negedge clk);
    check("rst_wren", wren, 0);
    check("rst_wraddr", wraddr, 0);
    check("rst_wrdata", wrdata, 0);
    check("rst_ready", byte_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while the first bit is strobing aborts the job
    b = 5'(($urandom));
    q_wr.push_back('{addr: {b, 6'd0}, data: 1'b1});
    load_bear = b; load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h81;
    wait_ready("abort_ready_timeout");
    @(negedge clk);
    byte_valid = 1'b0;
    guard = 0;
    while (!wren && guard < 20) begin @(negedge clk); guard++; end
    if (guard >= 20) flag("abort_wren_timeout");
    #1 rst_n = 1'b0;
    #1;
    check("abort_wren", wren, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", byte_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_queue", q_wr.size(), 0);

    // Directed load: bearing 5, one set bit at range 0
    for (int k = 0; k < 8; k++) begin
      ld_bytes[k] = (k == 0) ? 8'h01 : 8'h00;
      ld_gaps[k]  = 0;
    end
    do_load(5'd5);
    drain();

    // Host stalls 10 cycles in WAIT_BYTE before byte 4 (range 32)
    for (int k = 0; k < 8; k++) begin
      ld_bytes[k] = 8'($urandom);
      ld_gaps[k]  = (k == 4) ? 10 : 0;
    end
    do_load(5'($urandom));
    drain();

    // Randomized loads with occasional host stalls
    repeat (6) begin
      for (int k = 0; k < 8; k++) begin
        ld_bytes[k] = 8'($urandom);
        ld_gaps[k]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      end
      do_load(5'($urandom));
      drain();
    end

    // byte_valid while idle is a protocol error
    q_err.push_back(cyc + 1);
    byte_valid = 1'b1; byte_data = 8'($urandom);
    @(negedge clk);
    byte_valid = 1'b0;
    drain();

    // Clear with stray commands mid-run: each pulses err, clear unaffected
    issue_clear();
    repeat ($urandom_range(20, 300)) @(negedge clk);
    q_err.push_back(cyc + 1);
    load_bear = 5'($urandom); load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    repeat ($urandom_range(500, 3000)) @(negedge clk);
    q_err.push_back(cyc + 1);
    cmd_clr = 1'b1;
    @(negedge clk);
    cmd_clr = 1'b0;
    drain();

    // Simultaneous clear and load on the slower-timing instance: clear wins
    for (int i = 0; i < int'(CELLS); i++) q_wr2.push_back('{addr: ADDR_W'(i), data: 1'b0});
    q_done2.push_back(cyc + CELLS * S2 + 1);
    q_err2.push_back(cyc + 1);
    cmd_clr2 = 1'b1; load_start2 = 1'b1; load_bear2 = 5'($urandom);
    @(negedge clk);
    cmd_clr2 = 1'b0; load_start2 = 1'b0;
    drain();

    check("left_writes", q_wr.size(), 0);
    check("left_done", q_done.size(), 0);
    check("left_err", q_err.size(), 0);
    check("left_writes2", q_wr2.size(), 0);
    check("left_done2", q_done2.size(), 0);
    check("left_err2", q_err2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
